// File: rtl/column_feeder_pkg.sv
// column_feeder_pkg: FSM state encoding and default geometry for column_feeder.
// COLUMN_FEEDER_ZERO_PAD_EN adds one all-zero column on each side of every band.
package column_feeder_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, PUSH, DONE} state_t;
  localparam int DEF_RES = 8;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_IMG_W = 8;
  localparam int DEF_IMG_H = 8;
  localparam int DEF_ADDR_W = 16;
  localparam int CNT_W = 16;
`ifdef COLUMN_FEEDER_ZERO_PAD_EN
  localparam int PAD_COLS = 2;
`else
  localparam int PAD_COLS = 0;
`endif
endpackage

// File: rtl/column_addr_gen.sv
// column_addr_gen: band/column/row-in-column counters with multiplier-free address accumulators.
// Pad columns exist only when COLUMN_FEEDER_ZERO_PAD_EN is defined.
module column_addr_gen
  import column_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [ADDR_W-1:0] base,
  input  logic              step_k,
  input  logic              next_col,
  output logic [CNT_W-1:0]  k,
  output logic [ADDR_W-1:0] addr,
  output logic              last_k,
  output logic              last_col,
  output logic              last_band,
  output logic              pad,
  output logic              next_pad
);
  localparam logic [CNT_W-1:0] LK = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LC = CNT_W'(IMG_W + PAD_COLS - 1);
  localparam logic [CNT_W-1:0] LR = CNT_W'(IMG_H - WIDTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OFF = ADDR_W'(PAD_COLS / 2);
  logic [CNT_W-1:0] r_q, r_d, c_q, c_d, k_q, k_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d, addr_q, addr_d;
  assign k = k_q;
  assign addr = addr_q;
  assign last_k = k_q == LK;
  assign last_col = c_q == LC;
  assign last_band = r_q == LR;
`ifdef COLUMN_FEEDER_ZERO_PAD_EN
  assign pad = c_q == '0 || last_col;
  assign next_pad = last_col || c_q == CNT_W'(IMG_W + PAD_COLS - 2);
`else
  assign pad = 1'b0;
  assign next_pad = 1'b0;
`endif
  // col_q tracks the address of row r, column c; addr_q walks down the column by IMG_W
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    k_d = k_q;
    row_d = row_q;
    col_d = col_q;
    addr_d = addr_q;
    if (ld) begin
      r_d = '0;
      c_d = '0;
      k_d = '0;
      row_d = base;
      col_d = base - OFF;
      addr_d = base - OFF;
    end else if (next_col) begin
      r_d = last_col ? r_q + CNT_W'(1) : r_q;
      c_d = last_col ? '0 : c_q + CNT_W'(1);
      row_d = last_col ? row_q + STEP : row_q;
      col_d = last_col ? row_q + STEP - OFF : col_q + ADDR_W'(1);
      k_d = '0;
      addr_d = col_d;
    end else if (step_k) begin
      k_d = last_k ? '0 : k_q + CNT_W'(1);
      addr_d = addr_q + STEP;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
      row_q <= '0;
      col_q <= '0;
      addr_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
      k_q <= k_d;
      row_q <= row_d;
      col_q <= col_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: rtl/column_feeder.sv
// column_feeder: streams WIDTH-pixel image columns, band by band, from memory into a column FIFO.
// COLUMN_FEEDER_ZERO_PAD_EN adds a zero column before and after each band without reading memory.
module column_feeder
  import column_feeder_pkg::*;
#(
  parameter int RES = DEF_RES,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          img_base,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [RES-1:0]             mem_rd_data,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0][RES-1:0]  fifo_data,
  output logic                       fifo_clear,
  output logic                       busy,
  output logic                       done
);
  state_t state_q, state_d;
  logic [WIDTH-1:0][RES-1:0] data_q, data_d;
  logic [CNT_W-1:0] k;
  logic [ADDR_W-1:0] addr;
  logic last_k, last_col, last_band, pad, next_pad;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign fifo_clear = state_q == CLEAR;
  assign mem_rd_en = state_q == FETCH;
  assign mem_addr = mem_rd_en ? addr : '0;
  // write strobe must see fifo_full in the same cycle, so it is decoded rather than registered
  assign fifo_wr_en = state_q == PUSH && !fifo_full;
  assign fifo_data = data_q;
  column_addr_gen #(
    .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
  ) u_addr (
    .clk(clk), .rst(rst), .ld(state_q == IDLE && start), .base(img_base),
    .step_k(mem_rd_en), .next_col(fifo_wr_en), .k(k), .addr(addr), .last_k(last_k),
    .last_col(last_col), .last_band(last_band), .pad(pad), .next_pad(next_pad)
  );
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    case (state_q)
      IDLE: state_d = start ? CLEAR : IDLE;
      CLEAR: begin
        state_d = pad ? PUSH : FETCH;
        if (pad) data_d = '0;
      end
      FETCH: begin
        for (int i = 0; i < WIDTH - 1; i++) if (k == CNT_W'(i + 1)) data_d[i] = mem_rd_data;
        state_d = last_k ? DRAIN : FETCH;
      end
      DRAIN: begin
        data_d[WIDTH-1] = mem_rd_data;
        state_d = PUSH;
      end
      PUSH: if (!fifo_full) begin
        state_d = (last_col && last_band) ? DONE : next_pad ? PUSH : FETCH;
        if (next_pad) data_d = '0;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
    end
  end
endmodule

// File: doc/column_feeder.md
COLUMN_FEEDER -- requirements
Module: column_feeder

Interface
REQ-001 SHALL have parameter RES, default 8, pixel bit width.
REQ-002 SHALL have parameter WIDTH, default 3, pixels per column (kernel rows).
REQ-003 SHALL have parameters IMG_W, default 8, and IMG_H, default 8, image size in pixels; IMG_H >= WIDTH.
REQ-004 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 start  in  1  one-cycle request to stream a frame; honoured only in IDLE.
REQ-009 img_base  in  ADDR_W  frame base address, sampled on accepted start.
REQ-010 mem_rd_en  out  1  memory read strobe.
REQ-011 mem_addr  out  ADDR_W  memory read address.
REQ-012 mem_rd_data  in  RES  read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 fifo_full  in  1  downstream column-FIFO full flag.
REQ-014 fifo_wr_en  out  1  one-cycle column write strobe.
REQ-015 fifo_data  out  WIDTH x RES  column; element k = pixel of row r+k.
REQ-016 fifo_clear  out  1  one-cycle FIFO flush pulse.
REQ-017 busy  out  1  high from cycle after accepted start until DONE exits.
REQ-018 done  out  1  one-cycle pulse at frame end.

Function
REQ-019 SHALL implement states IDLE, CLEAR, FETCH, DRAIN, PUSH, DONE.
REQ-020 IDLE->CLEAR on start; CLEAR asserts fifo_clear for exactly one cycle, then FETCH.
REQ-021 FETCH SHALL issue WIDTH reads on consecutive cycles, k=0..WIDTH-1, mem_addr = img_base + (r+k)*IMG_W + c.
REQ-022 Read data for read k SHALL be captured into fifo_data[k] the following cycle; DRAIN captures the last element, then PUSH.
REQ-023 PUSH SHALL assert fifo_wr_en only in a cycle where fifo_full is low, hold fifo_data stable while stalled, and leave PUSH after the write.
REQ-024 Column order: c = 0..IMG_W-1 within band, bands r = 0..IMG_H-WIDTH (stride 1); total pushes (IMG_H-WIDTH+1)*IMG_W.
REQ-025 After the last push SHALL enter DONE (done=1 one cycle), then IDLE.
REQ-026 Addresses SHALL use a row-base accumulator (add IMG_W), no multiplier; arithmetic wraps modulo 2^ADDR_W.
REQ-027 start while busy SHALL be ignored; start and last push coincident SHALL not restart.
REQ-028 mem_rd_en SHALL be low outside FETCH; unloaded minimum is WIDTH+2 cycles per column.

Reset
REQ-029 On rst, state=IDLE, counters=0, and mem_rd_en, mem_addr, fifo_wr_en, fifo_clear, busy, done, fifo_data all 0, immediately and asynchronously.
REQ-030 rst mid-frame SHALL abort with no further reads or writes; a new start is required.

Configuration
REQ-031 Macro COLUMN_FEEDER_ZERO_PAD_EN defined: each band SHALL push IMG_W+2 columns, first and last all-zero, with no memory reads for them (FETCH/DRAIN skipped).
REQ-032 Macro undefined: exactly IMG_W columns per band, no pad logic present.

Structure
REQ-033 Package column_feeder_pkg SHALL hold the state enum and default parameter constants.
REQ-034 Sub-module column_addr_gen SHALL hold the r/c/k counters and address accumulator.

Verification
REQ-035 IMG_W=4, IMG_H=3, WIDTH=3, img_base=0, mem[i]=i, fifo_full=0 -> 4 pushes {0,4,8},{1,5,9},{2,6,10},{3,7,11}, one fifo_clear first, then done.
REQ-036 Same, fifo_full held high 5 cycles during first PUSH -> no fifo_wr_en while full, data stays {0,4,8}, write occurs the cycle full drops.
REQ-037 IMG_H=4, WIDTH=3 -> 8 pushes; fifth is {4,8,12}.
REQ-038 start pulsed again mid-frame -> ignored, exactly one done, push count unchanged.
REQ-039 rst asserted during FETCH -> all outputs 0 same cycle; new start replays from {0,4,8}.
REQ-040 With COLUMN_FEEDER_ZERO_PAD_EN, REQ-035 setup -> 6 pushes: {0,0,0}, four data columns, {0,0,0}; 12 reads total.
